pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and stage-control unit for the MIPS pipelined CPU. It tracks destination-register metadata for every post-ID stage in an internal shift pipeline. From that metadata it produces ID-stage forwarding selects, load-use stall, branch flush and per-stage enables. The datapath consumes `fwd_a`/`fwd_b` as mux selects over {regfile, stage 0..STAGES-1 result} and drives its stage registers from `if_en`/`id_en`/`id_flush`.

---
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bus: ID instruction metadata in, forwarding/stall/enable out.
interface pipe_hazard_ctrl_if #(
  parameter int STAGES = 3,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16,
  localparam int FW    = $clog2(STAGES+1)
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wen;
  logic [REG_AW-1:0] id_waddr;
  logic              id_is_load;
  logic              branch_taken;
  logic              ext_stall;
  logic              cnt_clr;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic              stall_id;
  logic              if_en;
  logic              id_en;
  logic              id_flush;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // datapath side
  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_wen, id_waddr, id_is_load, branch_taken, ext_stall, cnt_clr,
    input  fwd_a, fwd_b, stall_id, if_en, id_en, id_flush,
           stage_valid, stall_cnt, flush_cnt
  );

  // hazard unit side
  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_wen, id_waddr, id_is_load, branch_taken, ext_stall, cnt_clr,
    output fwd_a, fwd_b, stall_id, if_en, id_en, id_flush,
           stage_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / forwarding / stage-control unit: shift pipeline of destination
// metadata per post-ID stage, youngest-match forwarding, load-use stall.

// Per-stage source match; r0 is hardwired zero so it never matches.
module hz_stage_match #(
  parameter int REG_AW = 5
) (
  input  logic              i_valid,
  input  logic              i_wen,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic              i_rs_used,
  input  logic [REG_AW-1:0] i_rt_addr,
  input  logic              i_rt_used,
  output logic              o_rs_hit,
  output logic              o_rt_hit
);
  logic w_wr;
  assign w_wr     = i_valid & i_wen;
  assign o_rs_hit = w_wr & i_rs_used & (i_rs_addr != '0) & (i_waddr == i_rs_addr);
  assign o_rt_hit = w_wr & i_rt_used & (i_rt_addr != '0) & (i_waddr == i_rt_addr);
endmodule

module pipe_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 1,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  localparam int FW        = $clog2(STAGES+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  // per-stage entry fields, index 0 = youngest (EXE)
  logic [STAGES-1:0]             r_vld_pipe;
  logic [STAGES-1:0]             r_wen;
  logic [STAGES-1:0]             r_load;
  logic [STAGES-1:0][REG_AW-1:0] r_waddr;
  logic [CNT_W-1:0]              r_stall_cnt;
  logic [CNT_W-1:0]              r_flush_cnt;

  logic [STAGES-1:0] w_hit_a, w_hit_b;
  logic [FW-1:0]     w_fwd_a, w_fwd_b;
  logic              w_nr_a, w_nr_b;
  logic              w_stall, w_run, w_issue, w_flush;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      hz_stage_match #(.REG_AW(REG_AW)) u_match (
        .i_valid   (r_vld_pipe[g]),
        .i_wen     (r_wen[g]),
        .i_waddr   (r_waddr[g]),
        .i_rs_addr (bus.id_rs_addr),
        .i_rs_used (bus.id_rs_used),
        .i_rt_addr (bus.id_rt_addr),
        .i_rt_used (bus.id_rt_used),
        .o_rs_hit  (w_hit_a[g]),
        .o_rt_hit  (w_hit_b[g])
      );
    end
  endgenerate

  // Youngest match wins: scan oldest to youngest so the lowest stage overrides.
  // A load whose data is not yet out of its access stage marks the source not ready.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    w_nr_a  = 1'b0;
    w_nr_b  = 1'b0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (w_hit_a[k]) begin
        w_fwd_a = FW'(k+1);
        w_nr_a  = r_load[k] && (k < LOAD_STAGE);
      end
      if (w_hit_b[k]) begin
        w_fwd_b = FW'(k+1);
        w_nr_b  = r_load[k] && (k < LOAD_STAGE);
      end
    end
  end

  // rst_n gating keeps enables/flush low for the whole reset window
  assign w_stall = rst_n & bus.id_valid & (w_nr_a | w_nr_b);
  assign w_run   = rst_n & ~w_stall & ~bus.ext_stall;
  assign w_flush = w_run & bus.branch_taken & bus.id_valid;
  assign w_issue = bus.id_valid & ~w_stall;

  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.stall_id    = w_stall;
  assign bus.if_en       = w_run;
  assign bus.id_en       = w_run;
  assign bus.id_flush    = w_flush;
  assign bus.stage_valid = r_vld_pipe;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

  // Shift metadata down the pipe; a stalled/invalid ID slot enters as an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_wen      <= '0;
      r_load     <= '0;
      r_waddr    <= '0;
    end else if (!bus.ext_stall) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], w_issue};
      r_wen      <= {r_wen[STAGES-2:0],      w_issue & bus.id_wen};
      r_load     <= {r_load[STAGES-2:0],     w_issue & bus.id_is_load};
      r_waddr    <= {r_waddr[STAGES-2:0],    (w_issue ? bus.id_waddr : '0)};
    end
  end

  // Saturating event counters; clear beats increment. Frozen cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !bus.ext_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (STAGES=3, LOAD_STAGE=1, CNT_W=2).
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst_n;

  pipe_hazard_ctrl_if #(.STAGES(3), .REG_AW(5), .CNT_W(2)) hif ();

  pipe_hazard_ctrl #(.STAGES(3), .LOAD_STAGE(1), .REG_AW(5), .CNT_W(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    nm;
    bit [1:0] fa, fb;
    bit       st, en, fl;
    bit [2:0] sv;
    bit [1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // monitor: every expectation queued this cycle is checked half a period later
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t     e;
      bit [14:0] want;
      logic [14:0] got;
      e    = q.pop_front();
      want = {e.fa, e.fb, e.st, e.en, e.en, e.fl, e.sv, e.sc, e.fc};
      got  = {hif.fwd_a, hif.fwd_b, hif.stall_id, hif.if_en, hif.id_en, hif.id_flush,
              hif.stage_valid, hif.stall_cnt, hif.flush_cnt};
      n_chk++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s: got fa/fb/st/if/id/fl/sv/sc/fc=%b required %b", e.nm, got, want);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input bit [4:0] rs, input bit rsu,
                     input bit [4:0] rt, input bit rtu, input bit wen,
                     input bit [4:0] wa, input bit ld, input bit br,
                     input bit es, input bit clr);
    hif.id_valid     = v;
    hif.id_rs_addr   = rs;
    hif.id_rs_used   = rsu;
    hif.id_rt_addr   = rt;
    hif.id_rt_used   = rtu;
    hif.id_wen       = wen;
    hif.id_waddr     = wa;
    hif.id_is_load   = ld;
    hif.branch_taken = br;
    hif.ext_stall    = es;
    hif.cnt_clr      = clr;
  endtask

  task automatic chk(input string nm, input bit [1:0] fa, input bit [1:0] fb,
                     input bit st, input bit en, input bit fl, input bit [2:0] sv,
                     input bit [1:0] sc, input bit [1:0] fc);
    exp_t e;
    e.nm = nm; e.fa = fa; e.fb = fb; e.st = st; e.en = en; e.fl = fl;
    e.sv = sv; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) step();
    // reset: enables/flush forced low even with a valid taken branch in ID
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("reset", 0, 0, 0, 0, 0, 3'b000, 0, 0);
    step(); rst_n = 1'b1;

    // ALU chain: add r3, then sub reading r3 held in ID
    drv(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
    chk("alu_issue", 0, 0, 0, 1, 0, 3'b000, 0, 0);
    step(); drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_fwd1", 1, 0, 0, 1, 0, 3'b001, 0, 0);
    step(); chk("alu_fwd2", 2, 0, 0, 1, 0, 3'b011, 0, 0);
    step(); chk("alu_fwd3", 3, 0, 0, 1, 0, 3'b111, 0, 0);
    step(); chk("alu_fwd0", 0, 0, 0, 1, 0, 3'b111, 0, 0);

    // fill: r4, lw r0, r4  -> stage0=r4, stage1=lw r0, stage2=r4
    step(); drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    // lw r0 reading rs=r4 (youngest is stage0), rt=r0 never matches
    step(); drv(1, 4, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    chk("youngest", 1, 0, 0, 1, 0, 3'b111, 0, 0);
    // stage0 now holds lw r0: r0 sources neither forward nor stall
    step(); drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("r0_nomatch", 0, 0, 0, 1, 0, 3'b111, 0, 0);
    // r4 only in stage2 now; rt=r4 but unused
    step(); drv(1, 4, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("rt_unused", 3, 0, 0, 1, 0, 3'b111, 0, 0);

    // load-use: lw r5 then add rt=r5
    step(); drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
    chk("lw_issue", 0, 0, 0, 1, 0, 3'b111, 0, 0);
    step(); drv(1, 0, 0, 5, 1, 1, 6, 0, 0, 0, 0);
    chk("ldu_stall", 0, 1, 1, 0, 0, 3'b111, 0, 0);
    step(); chk("ldu_fwd", 0, 2, 0, 1, 0, 3'b110, 1, 0);

    // branch on a load-use operand: no flush while stalled, flush once ready
    step(); drv(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    chk("lw2_issue", 0, 0, 0, 1, 0, 3'b101, 1, 0);
    step(); drv(1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("br_stalled", 1, 0, 1, 0, 0, 3'b011, 1, 0);
    step(); chk("br_flush", 2, 0, 0, 1, 1, 3'b110, 2, 0);
    step(); idle();
    chk("flush_cnt", 0, 0, 0, 1, 0, 3'b101, 2, 1);

    // ext_stall freeze with a pending load-use: reported, not counted, pipe holds
    step(); drv(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drv(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("ext_freeze", 1, 0, 1, 0, 0, 3'b101, 2, 1);
      step();
    end
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ext_release", 1, 0, 1, 0, 0, 3'b101, 2, 1);

    // saturation of the 2-bit stall counter
    step(); drv(1, 8, 1, 0, 0, 1, 10, 1, 0, 0, 0);
    chk("lw3_issue", 2, 0, 0, 1, 0, 3'b010, 3, 1);
    step(); drv(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_stall", 0, 1, 1, 0, 0, 3'b101, 3, 1);
    step(); chk("sat_hold", 0, 2, 0, 1, 0, 3'b010, 3, 1);

    // clear coinciding with a flush: clear wins
    step(); drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("clr_pulse", 0, 0, 0, 1, 1, 3'b101, 3, 1);
    step(); idle();
    chk("cnt_clr", 0, 0, 0, 1, 0, 3'b011, 0, 0);

    // reset mid-operation with three valid writers in flight
    step(); drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(); drv(1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst", 1, 3, 0, 1, 0, 3'b111, 0, 0);
    step(); rst_n = 1'b0;
    chk("rst_mid", 0, 0, 0, 0, 0, 3'b000, 0, 0);

    step(); rst_n = 1'b1; idle();
    repeat (3) step();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
